// File: rtl/onehot_decoder_reg_pkg.sv
// Shared types and helpers for the registered one-hot decoder.
package onehot_dec_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      SCAN = 2'd2
   } state_e;

   // Scan prescaler width; SCAN_DIV is limited to 1..65535.
   localparam int DIV_W = 16;

   function automatic int sel_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/onehot_decoder_reg_if.sv
// Handshake, control and one-hot output bundle of onehot_decoder_reg.
interface onehot_decoder_reg_if
   import onehot_dec_pkg::*;
#(
   parameter int NUM_OUT = 16
);
   localparam int SEL_W = sel_width(NUM_OUT);

   logic               in_valid;
   logic               in_ready;
   logic [SEL_W-1:0]   sel;
   logic               clear;
   logic               scan_start;
   logic [NUM_OUT-1:0] out;
   logic               out_valid;
   logic               busy;
   logic               done;
   logic               err;

   modport master (
      output in_valid, sel, clear, scan_start,
      input  in_ready, out, out_valid, busy, done, err
   );

   modport slave (
      input  in_valid, sel, clear, scan_start,
      output in_ready, out, out_valid, busy, done, err
   );

endinterface

// File: rtl/onehot_decoder_reg_dec_scan_timer.sv
// Scan timing: SCAN_DIV prescaler plus output index counter; idles at zero
// whenever run_i is low so every sweep starts at index 0.
module dec_scan_timer
   import onehot_dec_pkg::*;
#(
   parameter int NUM_OUT  = 16,
   parameter int SEL_W    = sel_width(NUM_OUT),
   parameter int SCAN_DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic run_i,
   output logic step_o,
   output logic last_o
);

   logic [DIV_W-1:0] div_q, div_d;
   logic [SEL_W-1:0] idx_q, idx_d;

   assign step_o = run_i & (div_q == DIV_W'(SCAN_DIV - 1));
   assign last_o = (idx_q == SEL_W'(NUM_OUT - 1));

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      div_d = '0;
      idx_d = '0;
      if (run_i) begin
         if (step_o) begin
            idx_d = last_o ? '0 : idx_q + 1'b1;
         end else begin
            div_d = div_q + 1'b1;
            idx_d = idx_q;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
         idx_q <= '0;
      end else begin
         div_q <= div_d;
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/onehot_decoder_reg.sv
// Registered binary-to-one-hot decoder with hold, clear and self-timed scan.
// Define ONEHOT_DEC_ERR_EN to pulse err on an illegal select code.
module onehot_decoder_reg
   import onehot_dec_pkg::*;
#(
   parameter int NUM_OUT  = 16,
   parameter int SEL_W    = sel_width(NUM_OUT),
   parameter int SCAN_DIV = 1
) (
   input logic                 clk,
   input logic                 rst,
   onehot_decoder_reg_if.slave dec_if
);

   state_e             state_q, state_d;
   logic [NUM_OUT-1:0] out_q, out_d;
   logic               done_q, done_d;
   logic               accept;
   logic               legal;
   logic               step;
   logic               last;

   dec_scan_timer #(
      .NUM_OUT  (NUM_OUT),
      .SEL_W    (SEL_W),
      .SCAN_DIV (SCAN_DIV)
   ) u_scan_timer (
      .clk    (clk),
      .rst    (rst),
      .run_i  (state_q == SCAN),
      .step_o (step),
      .last_o (last)
   );

   // scan_start has priority over the input, even though in_ready stays high.
   assign accept = dec_if.in_valid & dec_if.in_ready & ~dec_if.clear & ~dec_if.scan_start;
   assign legal  = (int'(dec_if.sel) < NUM_OUT);

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      done_d  = 1'b0;
      if (dec_if.clear) begin
         state_d = IDLE;
         out_d   = '0;
      end else if (dec_if.scan_start && state_q != SCAN) begin
         state_d = SCAN;
         out_d   = NUM_OUT'(1);
      end else if (state_q == SCAN) begin
         if (step && last) begin
            state_d = IDLE;
            out_d   = '0;
            done_d  = 1'b1;
         end else if (step) begin
            out_d = out_q << 1;
         end
      end else if (accept) begin
         if (legal) begin
            state_d = HOLD;
            out_d   = NUM_OUT'(1) << dec_if.sel;
         end else begin
            state_d = IDLE;
            out_d   = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         out_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         done_q  <= done_d;
      end
   end

`ifdef ONEHOT_DEC_ERR_EN
   logic err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= accept & ~legal;
      end
   end

   assign dec_if.err = err_q;
`else
   assign dec_if.err = 1'b0;
`endif

   assign dec_if.in_ready  = (state_q != SCAN);
   assign dec_if.out       = out_q;
   assign dec_if.out_valid = (state_q == HOLD);
   assign dec_if.busy      = (state_q == SCAN);
   assign dec_if.done      = done_q;

endmodule

// File: tb/tb_onehot_decoder_reg.sv
// Self-checking bench for onehot_decoder_reg: vector table, corner sequences
// and a randomized run against a behavioural model.
module tb_onehot_decoder_reg;

   localparam int N   = 16;
   localparam int DIV = 2;
   localparam int N2  = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   onehot_decoder_reg_if #(.NUM_OUT(N))  bus  ();
   onehot_decoder_reg_if #(.NUM_OUT(N2)) bus2 ();

   onehot_decoder_reg #(.NUM_OUT(N), .SCAN_DIV(DIV)) dut (
      .clk    (clk),
      .rst    (rst),
      .dec_if (bus)
   );

   onehot_decoder_reg #(.NUM_OUT(N2), .SCAN_DIV(1)) dut2 (
      .clk    (clk),
      .rst    (rst),
      .dec_if (bus2)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        vld;
      logic [3:0]  sel;
      logic        clr;
      logic        ss;
      logic [15:0] out;
      logic        ov;
      logic        busy;
   } vec_t;

   vec_t vt[11];

   // Behavioural model: mode 0 idle, 1 holding, 2 scanning; t = cycles into scan.
   int          m_mode;
   int          m_t;
   logic [15:0] m_out;
   logic        m_done;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.in_valid   = 1'b0;
      bus.sel        = '0;
      bus.clear      = 1'b0;
      bus.scan_start = 1'b0;
   endtask

   task automatic model_edge(input logic vld, input int s, input logic clr, input logic ss);
      m_done = 1'b0;
      if (clr) begin
         m_mode = 0;
         m_out  = '0;
      end else if (ss && m_mode != 2) begin
         m_mode = 2;
         m_t    = 0;
         m_out  = 16'h0001;
      end else if (m_mode == 2) begin
         m_t++;
         if (m_t == N * DIV) begin
            m_mode = 0;
            m_out  = '0;
            m_done = 1'b1;
         end else begin
            m_out = 16'(1) << (m_t / DIV);
         end
      end else if (vld) begin
         if (s < N) begin
            m_mode = 1;
            m_out  = 16'(1) << s;
         end else begin
            m_mode = 0;
            m_out  = '0;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic seen_done;
      logic exp_err;

      // in, sel, clr, ss  ->  out, out_valid, busy (after the edge)
      vt[0]  = '{1'b1, 4'd5,  1'b0, 1'b0, 16'h0020, 1'b1, 1'b0};
      vt[1]  = '{1'b0, 4'd0,  1'b0, 1'b0, 16'h0020, 1'b1, 1'b0};
      vt[2]  = '{1'b1, 4'd0,  1'b0, 1'b0, 16'h0001, 1'b1, 1'b0};
      vt[3]  = '{1'b1, 4'd15, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b0};
      vt[4]  = '{1'b1, 4'd2,  1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
      vt[5]  = '{1'b0, 4'd0,  1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
      vt[6]  = '{1'b1, 4'd3,  1'b0, 1'b1, 16'h0001, 1'b0, 1'b1};
      vt[7]  = '{1'b1, 4'd3,  1'b0, 1'b0, 16'h0001, 1'b0, 1'b1};
      vt[8]  = '{1'b0, 4'd0,  1'b0, 1'b1, 16'h0002, 1'b0, 1'b1};
      vt[9]  = '{1'b0, 4'd0,  1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
      vt[10] = '{1'b1, 4'd3,  1'b0, 1'b0, 16'h0008, 1'b1, 1'b0};

`ifdef ONEHOT_DEC_ERR_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif

      idle_in();
      bus2.in_valid   = 1'b0;
      bus2.sel        = '0;
      bus2.clear      = 1'b0;
      bus2.scan_start = 1'b0;

      // Reset state
      #12;
      check("rst_out",      bus.out,       0);
      check("rst_ov",       bus.out_valid, 0);
      check("rst_busy",     bus.busy,      0);
      check("rst_done",     bus.done,      0);
      check("rst_err2",     bus2.err,      0);
      @(negedge clk);
      rst = 1'b0;
      step();
      check("rst_in_ready", bus.in_ready,  1);
      check("rst_out2",     bus.out,       0);

      // Vector table
      for (int i = 0; i < 11; i++) begin
         bus.in_valid   = vt[i].vld;
         bus.sel        = vt[i].sel;
         bus.clear      = vt[i].clr;
         bus.scan_start = vt[i].ss;
         step();
         check($sformatf("vec%0d_out", i),  bus.out,       vt[i].out);
         check($sformatf("vec%0d_ov", i),   bus.out_valid, vt[i].ov);
         check($sformatf("vec%0d_busy", i), bus.busy,      vt[i].busy);
      end
      idle_in();

      // Hold for 10 cycles
      bus.in_valid = 1'b1;
      bus.sel      = 4'd5;
      step();
      idle_in();
      for (int i = 0; i < 10; i++) begin
         check("hold_out", bus.out, 16'h0020);
         check("hold_ov",  bus.out_valid, 1);
         step();
      end

      // Back-to-back replacement, no zero gap
      bus.in_valid = 1'b1;
      bus.sel      = 4'd0;
      step();
      check("b2b_first", bus.out, 16'h0001);
      bus.sel = 4'd15;
      step();
      check("b2b_second", bus.out, 16'h8000);
      idle_in();

      // Full scan sweep
      bus.scan_start = 1'b1;
      step();
      bus.scan_start = 1'b0;
      for (int i = 0; i < N * DIV; i++) begin
         check("scan_out",   bus.out,      32'(1) << (i / DIV));
         check("scan_busy",  bus.busy,     1);
         check("scan_ready", bus.in_ready, 0);
         check("scan_done",  bus.done,     0);
         step();
      end
      check("scan_end_out",  bus.out,      0);
      check("scan_end_busy", bus.busy,     0);
      check("scan_end_done", bus.done,     1);
      check("scan_end_rdy",  bus.in_ready, 1);
      step();
      check("scan_done_pulse", bus.done, 0);

      // Clear mid-scan at index 7
      bus.scan_start = 1'b1;
      step();
      bus.scan_start = 1'b0;
      for (int c = 0; c < 100 && bus.out !== 16'h0080; c++) step();
      check("clr_reach_idx7", bus.out, 16'h0080);
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
      check("clr_out",  bus.out,       0);
      check("clr_busy", bus.busy,      0);
      check("clr_ov",   bus.out_valid, 0);
      seen_done = bus.done;
      for (int c = 0; c < 40; c++) begin
         step();
         seen_done = seen_done | bus.done;
      end
      check("clr_no_done", seen_done, 0);
      bus.in_valid = 1'b1;
      bus.sel      = 4'd3;
      step();
      idle_in();
      check("clr_then_sel3", bus.out,       16'h0008);
      check("clr_then_ov",   bus.out_valid, 1);

      // Asynchronous reset between edges while holding
      bus.in_valid = 1'b1;
      bus.sel      = 4'd5;
      step();
      idle_in();
      check("arst_pre_out", bus.out, 16'h0020);
      #2;
      rst = 1'b1;
      #1;
      check("arst_out", bus.out,       0);
      check("arst_ov",  bus.out_valid, 0);
      @(negedge clk);
      rst = 1'b0;

      // Illegal code on the 10-output instance
      bus2.in_valid = 1'b1;
      bus2.sel      = 4'd9;
      step();
      check("n10_sel9_out", bus2.out,       10'h200);
      check("n10_sel9_ov",  bus2.out_valid, 1);
      bus2.sel = 4'd12;
      step();
      bus2.in_valid = 1'b0;
      check("n10_ill_out", bus2.out,       0);
      check("n10_ill_ov",  bus2.out_valid, 0);
      check("n10_ill_err", bus2.err,       exp_err);
      check("n10_ill_rdy", bus2.in_ready,  1);
      step();
      check("n10_err_pulse", bus2.err, 0);

      // Randomized run against the model
      rst = 1'b1;
      #3;
      rst = 1'b0;
      m_mode = 0;
      m_t    = 0;
      m_out  = '0;
      m_done = 1'b0;
      for (int i = 0; i < 400; i++) begin
         logic       vld, clr, ss;
         logic [3:0] s;
         vld = 1'($urandom_range(0, 1));
         s   = 4'($urandom_range(0, 15));
         clr = ($urandom_range(0, 59) == 0);
         ss  = ($urandom_range(0, 11) == 0);
         bus.in_valid   = vld;
         bus.sel        = s;
         bus.clear      = clr;
         bus.scan_start = ss;
         model_edge(vld, int'(s), clr, ss);
         step();
         check("rnd_out",   bus.out,       m_out);
         check("rnd_ov",    bus.out_valid, (m_mode == 1));
         check("rnd_busy",  bus.busy,      (m_mode == 2));
         check("rnd_ready", bus.in_ready,  (m_mode != 2));
         check("rnd_done",  bus.done,      m_done);
      end
      idle_in();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
